mxm_operand_sequencer: RTL and testbench

- Upstream feeder for the streaming matrix-multiply core (one A/X operand pair per cycle, one Y per N-element dot product).
- Holds A (MxN) and X (NxP) in local buffers, loaded through a write port.
- On start, streams operand pairs in the order the core consumes them: n innermost, m middle, p outermost.
- Carries dot-product boundary flags and indices so the downstream stage can align Y with its (m,p) position.

---
 rtl/mxm_operand_sequencer_if.sv | 58 +++++
 rtl/mxm_operand_sequencer.sv | 244 ++++++++++++++++++++++++
 tb/tb_mxm_operand_sequencer.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/mxm_operand_sequencer_if.sv
// ---------------------------------------------------------------------------
// mxm_operand_sequencer_if
//
// Bundles the load port, the start/status pair and the streaming operand
// output of mxm_operand_sequencer.
//
//   ld_en / ld_sel / ld_addr / ld_data : operand buffer write port
//                                        (ld_sel 0 = A buffer, 1 = X buffer)
//   start                              : single-cycle pass request
//   out_ready                          : downstream accepts current pair
//   a_out / x_out                      : operand pair
//   out_valid                          : pair, flags and indices valid
//   dot_first / dot_last               : pair is n==0 / n==N-1
//   row_idx / col_idx                  : (m,p) of the pair
//   busy / done                        : pass in progress / end-of-pass pulse
//
// Modports: slave = the sequencer, master = the block driving it.
// ---------------------------------------------------------------------------
interface mxm_operand_sequencer_if #(
    parameter int W = 8,
    parameter int M = 200,
    parameter int N = 100,
    parameter int P = 120
);
    localparam int AAW = $clog2(M * N);
    localparam int XAW = $clog2(N * P);
    localparam int LAW = (AAW > XAW) ? AAW : XAW;
    localparam int MW  = (M > 1) ? $clog2(M) : 1;
    localparam int PW  = (P > 1) ? $clog2(P) : 1;

    logic           ld_en;
    logic           ld_sel;
    logic [LAW-1:0] ld_addr;
    logic [W-1:0]   ld_data;
    logic           start;
    logic           out_ready;
    logic [W-1:0]   a_out;
    logic [W-1:0]   x_out;
    logic           out_valid;
    logic           dot_first;
    logic           dot_last;
    logic [MW-1:0]  row_idx;
    logic [PW-1:0]  col_idx;
    logic           busy;
    logic           done;

    modport slave (
        input  ld_en, ld_sel, ld_addr, ld_data, start, out_ready,
        output a_out, x_out, out_valid, dot_first, dot_last,
               row_idx, col_idx, busy, done
    );

    modport master (
        output ld_en, ld_sel, ld_addr, ld_data, start, out_ready,
        input  a_out, x_out, out_valid, dot_first, dot_last,
               row_idx, col_idx, busy, done
    );
endinterface

// File: rtl/mxm_operand_sequencer.sv
// ---------------------------------------------------------------------------
// mxm_operand_sequencer
//
// Operand feeder for the streaming matrix-multiply core. A (MxN) and X (NxP)
// live in local single-port synchronous RAMs loaded while idle. A start pulse
// streams every (A,X) pair of the product with n innermost, m middle and
// p outermost, one pair per accepted cycle, together with dot-product
// boundary flags and the (m,p) indices the pair contributes to.
//
// Ports:
//   clk  : clock
//   rst  : synchronous, active-high reset (buffer contents survive it)
//   bus  : mxm_operand_sequencer_if.slave
//            ld_en/ld_sel/ld_addr/ld_data  buffer write port (idle only,
//                                          out-of-range addresses dropped)
//            start                         begin a full M*N*P pass
//            out_ready                     downstream accept
//            a_out/x_out/out_valid         operand pair stream
//            dot_first/dot_last            n==0 / n==N-1 markers
//            row_idx/col_idx               m / p of the pair
//            busy/done                     pass active / end-of-pass pulse
//
// Build option:
//   MXM_SEQ_X_ROW_MAJOR_EN  defined   : X word address = n*P + p
//                           undefined : X word address = p*N + n
//   A addressing and all timing are the same in both builds.
// ---------------------------------------------------------------------------
module mxm_operand_sequencer #(
    parameter int W = 8,
    parameter int M = 200,
    parameter int N = 100,
    parameter int P = 120
) (
    input  logic                  clk,
    input  logic                  rst,
    mxm_operand_sequencer_if.slave bus
);
    localparam int AAW = $clog2(M * N);
    localparam int XAW = $clog2(N * P);
    localparam int LAW = (AAW > XAW) ? AAW : XAW;
    localparam int MW  = (M > 1) ? $clog2(M) : 1;
    localparam int NW  = (N > 1) ? $clog2(N) : 1;
    localparam int PW  = (P > 1) ? $clog2(P) : 1;

    // One extra bit so the word counts themselves are representable.
    localparam logic [LAW:0] A_WORDS = (LAW + 1)'(M * N);
    localparam logic [LAW:0] X_WORDS = (LAW + 1)'(N * P);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_FLUSH,
        ST_DONE
    } state_t;

    state_t state_q, state_d;

    logic [NW-1:0]  n_q, n_d;
    logic [MW-1:0]  m_q, m_d;
    logic [PW-1:0]  p_q, p_d;

    // Running address bases so no multiplier sits in the issue path.
    // a_addr_q tracks m*N+n directly (it simply counts through A once per p).
    // x_base_q is p*N in the column-major build and n*P in the row-major one.
    logic [AAW-1:0] a_addr_q, a_addr_d;
    logic [XAW-1:0] x_base_q, x_base_d;
    logic [XAW-1:0] x_addr;

    logic last_n, last_m, last_p, terminal;
    logic advance, issue;
    logic a_wr, x_wr;

    // Output stage (RAM read register plus the sideband that travels with it)
    logic           vld_p1_q;
    logic [W-1:0]   a_p1_q;
    logic [W-1:0]   x_p1_q;
    logic           first_p1_q;
    logic           last_p1_q;
    logic [MW-1:0]  row_p1_q;
    logic [PW-1:0]  col_p1_q;

    logic [W-1:0] a_mem [M * N];
    logic [W-1:0] x_mem [N * P];

    assign last_n   = (n_q == NW'(N - 1));
    assign last_m   = (m_q == MW'(M - 1));
    assign last_p   = (p_q == PW'(P - 1));
    assign terminal = last_n && last_m && last_p;

    // The output register can take a new pair when empty or being drained.
    assign advance = !vld_p1_q || bus.out_ready;
    assign issue   = (state_q == ST_ISSUE) && advance;

`ifdef MXM_SEQ_X_ROW_MAJOR_EN
    assign x_addr = x_base_q + XAW'(p_q);
`else
    assign x_addr = x_base_q + XAW'(n_q);
`endif

    // Writes only land while idle, so the single RAM port is never shared
    // between a write and a read in the same cycle.
    assign a_wr = bus.ld_en && !bus.ld_sel && (state_q == ST_IDLE)
                  && ({1'b0, bus.ld_addr} < A_WORDS);
    assign x_wr = bus.ld_en &&  bus.ld_sel && (state_q == ST_IDLE)
                  && ({1'b0, bus.ld_addr} < X_WORDS);

    // ---- control: state and counter registers ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            n_q      <= '0;
            m_q      <= '0;
            p_q      <= '0;
            a_addr_q <= '0;
            x_base_q <= '0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            m_q      <= m_d;
            p_q      <= p_d;
            a_addr_q <= a_addr_d;
            x_base_q <= x_base_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        m_d      = m_q;
        p_d      = p_q;
        a_addr_d = a_addr_q;
        x_base_d = x_base_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d  = ST_ISSUE;
                    n_d      = '0;
                    m_d      = '0;
                    p_d      = '0;
                    a_addr_d = '0;
                    x_base_d = '0;
                end
            end

            ST_ISSUE: begin
                if (advance) begin
                    if (terminal) begin
                        // Counters park on the final position; start clears them.
                        state_d = ST_FLUSH;
                    end else begin
                        if (!last_n) begin
                            n_d = n_q + 1'b1;
                        end else begin
                            n_d = '0;
                            if (!last_m) begin
                                m_d = m_q + 1'b1;
                            end else begin
                                m_d = '0;
                                p_d = p_q + 1'b1;
                            end
                        end

                        a_addr_d = (last_n && last_m) ? '0 : a_addr_q + 1'b1;
`ifdef MXM_SEQ_X_ROW_MAJOR_EN
                        x_base_d = last_n ? '0 : x_base_q + XAW'(P);
`else
                        x_base_d = (last_n && last_m) ? x_base_q + XAW'(N) : x_base_q;
`endif
                    end
                end
            end

            ST_FLUSH: begin
                if (vld_p1_q && bus.out_ready) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ---- buffer write ----
    always_ff @(posedge clk) begin
        if (a_wr) begin
            a_mem[bus.ld_addr[AAW-1:0]] <= bus.ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (x_wr) begin
            x_mem[bus.ld_addr[XAW-1:0]] <= bus.ld_data;
        end
    end

    // ---- p1: RAM read registers (hold while read enable is low) ----
    always_ff @(posedge clk) begin
        if (rst) begin
            a_p1_q <= '0;
            x_p1_q <= '0;
        end else if (issue) begin
            a_p1_q <= a_mem[a_addr_q];
            x_p1_q <= x_mem[x_addr];
        end
    end

    // ---- p1: valid and sideband, registered alongside the read data ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q   <= 1'b0;
            first_p1_q <= 1'b0;
            last_p1_q  <= 1'b0;
            row_p1_q   <= '0;
            col_p1_q   <= '0;
        end else if (issue) begin
            vld_p1_q   <= 1'b1;
            first_p1_q <= (n_q == '0);
            last_p1_q  <= last_n;
            row_p1_q   <= m_q;
            col_p1_q   <= p_q;
        end else if (advance) begin
            // Drained with nothing new to issue; the payload keeps its value.
            vld_p1_q   <= 1'b0;
        end
    end

    assign bus.a_out     = a_p1_q;
    assign bus.x_out     = x_p1_q;
    assign bus.out_valid = vld_p1_q;
    assign bus.dot_first = first_p1_q;
    assign bus.dot_last  = last_p1_q;
    assign bus.row_idx   = row_p1_q;
    assign bus.col_idx   = col_p1_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_mxm_operand_sequencer.sv
module tb_mxm_operand_sequencer;
    localparam int W   = 8;
    localparam int M   = 2;
    localparam int N   = 3;
    localparam int P   = 2;
    localparam int T   = M * N * P;
    localparam int AAW = $clog2(M * N);
    localparam int XAW = $clog2(N * P);
    localparam int LAW = (AAW > XAW) ? AAW : XAW;

    logic clk = 1'b0;
    logic rst;

    int checks = 0;
    int errors = 0;

    // Reference contents of the two buffers
    logic [W-1:0] mA [M * N];
    logic [W-1:0] mX [N * P];

    // Expected stream for one pass
    logic [W-1:0] ea [T];
    logic [W-1:0] ex [T];
    int           ef [T];
    int           el [T];
    int           er [T];
    int           ec [T];

    mxm_operand_sequencer_if #(.W(W), .M(M), .N(N), .P(P)) bus ();

    mxm_operand_sequencer #(.W(W), .M(M), .N(N), .P(P)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Pass order straight from the loop nest: p outer, m middle, n inner.
    function automatic void build_exp();
        int k;
        k = 0;
        for (int p = 0; p < P; p++)
            for (int m = 0; m < M; m++)
                for (int n = 0; n < N; n++) begin
                    ea[k] = mA[m * N + n];
`ifdef MXM_SEQ_X_ROW_MAJOR_EN
                    ex[k] = mX[n * P + p];
`else
                    ex[k] = mX[p * N + n];
`endif
                    ef[k] = (n == 0) ? 1 : 0;
                    el[k] = (n == N - 1) ? 1 : 0;
                    er[k] = m;
                    ec[k] = p;
                    k++;
                end
    endfunction

    task automatic load(input bit sel, input int addr, input int data);
        @(negedge clk);
        bus.ld_en   = 1'b1;
        bus.ld_sel  = sel;
        bus.ld_addr = LAW'(addr);
        bus.ld_data = W'(data);
        if (!sel && addr < M * N) mA[addr] = W'(data);
        if (sel && addr < N * P)  mX[addr] = W'(data);
        @(negedge clk);
        bus.ld_en = 1'b0;
    endtask

    // mode 0: ready high; 1: random ready; 2: ready low 3 cycles at pair 4
    task automatic run_pass(input string tag, input int mode, input bit inj,
                            input int rst_at, input bit ld_start, input int ld_val);
        int  k, cyc, stalls, vcyc, gaps, s3;
        bit  rdy;
        k = 0; cyc = 0; stalls = 0; vcyc = 0; gaps = 0; s3 = 0;

        @(negedge clk);
        chk({tag, "_idle_busy"}, bus.busy, 0);
        chk({tag, "_idle_done"}, bus.done, 0);
        bus.start     = 1'b1;
        bus.out_ready = 1'b1;
        if (ld_start) begin
            bus.ld_en   = 1'b1;
            bus.ld_sel  = 1'b0;
            bus.ld_addr = '0;
            bus.ld_data = W'(ld_val);
            mA[0] = W'(ld_val);
        end
        build_exp();

        @(negedge clk);
        bus.start = 1'b0;
        bus.ld_en = 1'b0;
        chk({tag, "_busy"}, bus.busy, 1);
        chk({tag, "_pre_valid"}, bus.out_valid, 0);

        while (k < T && cyc < 400) begin
            @(negedge clk);
            cyc++;
            bus.start = 1'b0;
            bus.ld_en = 1'b0;
            chk({tag, "_done_early"}, bus.done, 0);
            if (!bus.out_valid) begin
                gaps++;
                bus.out_ready = 1'b1;
            end else begin
                vcyc++;
                if (rst_at >= 0 && k == rst_at) begin
                    rst = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                    chk({tag, "_rst_valid"}, bus.out_valid, 0);
                    chk({tag, "_rst_busy"}, bus.busy, 0);
                    chk({tag, "_rst_done"}, bus.done, 0);
                    chk({tag, "_rst_a"}, bus.a_out, 0);
                    chk({tag, "_rst_x"}, bus.x_out, 0);
                    chk({tag, "_rst_first"}, bus.dot_first, 0);
                    chk({tag, "_rst_row"}, bus.row_idx, 0);
                    chk({tag, "_rst_col"}, bus.col_idx, 0);
                    repeat (3) begin
                        @(negedge clk);
                        chk({tag, "_rst_nodone"}, bus.done, 0);
                        chk({tag, "_rst_idle"}, bus.busy, 0);
                    end
                    return;
                end
                chk({tag, "_a"}, bus.a_out, ea[k]);
                chk({tag, "_x"}, bus.x_out, ex[k]);
                chk({tag, "_first"}, bus.dot_first, ef[k]);
                chk({tag, "_last"}, bus.dot_last, el[k]);
                chk({tag, "_row"}, bus.row_idx, er[k]);
                chk({tag, "_col"}, bus.col_idx, ec[k]);
                if (mode == 1) begin
                    rdy = ($urandom_range(0, 3) != 0);
                end else if (mode == 2 && k == 4 && s3 < 3) begin
                    rdy = 1'b0;
                    s3++;
                end else begin
                    rdy = 1'b1;
                end
                if (inj && k == 5) begin
                    bus.start   = 1'b1;
                    bus.ld_en   = 1'b1;
                    bus.ld_sel  = 1'b0;
                    bus.ld_addr = '0;
                    bus.ld_data = W'(99);
                end
                bus.out_ready = rdy;
                if (rdy) k++;
                else stalls++;
            end
        end

        chk({tag, "_completed"}, k, T);
        chk({tag, "_bubbles"}, gaps, 0);
        chk({tag, "_valid_cycles"}, vcyc, T + stalls);
        if (mode == 2) chk({tag, "_stalls"}, stalls, 3);
        bus.start = 1'b0;
        bus.ld_en = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_done"}, bus.done, 1);
        chk({tag, "_done_valid"}, bus.out_valid, 0);
        chk({tag, "_done_busy"}, bus.busy, 1);
    endtask

    initial begin
        rst           = 1'b1;
        bus.ld_en     = 1'b0;
        bus.ld_sel    = 1'b0;
        bus.ld_addr   = '0;
        bus.ld_data   = '0;
        bus.start     = 1'b0;
        bus.out_ready = 1'b1;

        repeat (3) @(negedge clk);
        chk("reset_valid", bus.out_valid, 0);
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.done, 0);
        chk("reset_first", bus.dot_first, 0);
        chk("reset_last", bus.dot_last, 0);
        chk("reset_a", bus.a_out, 0);
        chk("reset_x", bus.x_out, 0);
        chk("reset_row", bus.row_idx, 0);
        chk("reset_col", bus.col_idx, 0);
        rst = 1'b0;

        for (int i = 0; i < M * N; i++) load(1'b0, i, i + 1);
        for (int i = 0; i < N * P; i++) load(1'b1, i, i + 10);

        run_pass("basic", 0, 1'b0, -1, 1'b0, 0);
        run_pass("stall", 2, 1'b0, -1, 1'b0, 0);
        run_pass("inject", 0, 1'b1, -1, 1'b0, 0);
        run_pass("after_inject", 0, 1'b0, -1, 1'b0, 0);
        run_pass("abort", 0, 1'b0, 7, 1'b0, 0);
        run_pass("restart", 0, 1'b0, -1, 1'b0, 0);

        load(1'b0, 6, 77);
        load(1'b1, 7, 88);
        run_pass("oob_load", 0, 1'b0, -1, 1'b0, 0);

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < M * N; i++) load(1'b0, i, int'($urandom_range(0, 255)));
            for (int i = 0; i < N * P; i++) load(1'b1, i, int'($urandom_range(0, 255)));
            repeat (3) load(1'(($urandom & 1)), int'($urandom_range(0, 7)),
                            int'($urandom_range(0, 255)));
            run_pass("random", 1, 1'b0, -1, 1'b1, int'($urandom_range(0, 255)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
